regfile: RTL and testbench
==========================

# regfile

Architectural register file with rename tags for the Tomasulo core. Holds 32 × 32-bit integer registers plus a 5-bit ROB nick per register naming the in-flight producer. Receives rename allocations and in-order commits from the reorder buffer (the far end of its nick and commit interfaces). Serves dispatch's two source-operand lookups as either a ready value or a pending nick.

## Interface
- No parameters. Widths are fixed: name 5 b, nick 5 b (0 = none, 1..31 valid), data 32 b.
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; when low, all state holds.
- iclr  in  1  misprediction flush from ROB.
- iROB_nick_en  in  1  rename allocation valid.
- iROB_nick  in  5  nick assigned to the new producer.
- iROB_nick_regnm  in  5  destination register of the new producer.
- iROB_en  in  1  commit valid.
- iROB_rd_regnm  in  5  committing destination register.
- iROB_rd_dt  in  32  committing result.
- iROB_rd_nick  in  5  nick of the committing entry.
- iDP_rs1_regnm  in  5  source 1 register name.
- iDP_rs2_regnm  in  5  source 2 register name.
- oDP_rs1_dt  out  32  source 1 value; meaningful only when oDP_rs1_nick = 0.
- oDP_rs1_nick  out  5  source 1 pending producer; 0 = value ready.
- oDP_rs2_dt  out  32  source 2 value; meaningful only when oDP_rs2_nick = 0.
- oDP_rs2_nick  out  5  source 2 pending producer; 0 = value ready.

## Operation
- State:
  - dt[0..31], 32 b each.
  - nick[0..31], 5 b each.
- Reset (async): all dt and all nick cleared to 0.
- Reads are combinational from current state.
  - A register with nick ≠ 0 outputs that nick, and dt is don't-care (driven 0).
  - Register 0 always reads dt = 0, nick = 0.
- Commit (iROB_en & rdy, regnm ≠ 0):
  - dt[regnm] ← iROB_rd_dt.
  - nick[regnm] ← 0 only if nick[regnm] == iROB_rd_nick; a younger rename keeps its tag.
- Rename (iROB_nick_en & rdy & !iclr, regnm ≠ 0): nick[regnm] ← iROB_nick.
- Commit and rename to the same register in the same cycle:
  - dt is updated by the commit.
  - nick becomes the new rename nick (rename wins).
- Flush (iclr & rdy):
  - All nick ← 0.
  - A same-cycle commit still writes dt.
  - A same-cycle rename is dropped.
- Writes to register 0 (commit or rename) are ignored.
- rdy low: no state changes; reads remain live.
- A rename of an instruction's rd is visible only from the next cycle, so the same instruction's rs lookup sees the prior producer.

## Timing
- Read latency: 0 cycles (combinational).
- Commit data visible to reads the cycle after iROB_en.
- Rename tag visible the cycle after iROB_nick_en.
- Flush effect (all ready) visible the cycle after iclr.
- No handshake back-pressure: every valid commit and rename is accepted in its cycle.
- Reset mid-operation wipes all state immediately, regardless of clk/rdy.

## Configuration
- RF_COMMIT_BYPASS_EN defined:
  - A read whose register has nick == iROB_rd_nick, with iROB_en high and regnm matching in the same cycle, returns dt = iROB_rd_dt and nick = 0 combinationally.
- RF_COMMIT_BYPASS_EN not defined:
  - That read returns the stored nick; the value becomes ready one cycle later.

## Test plan
- Reset then read x5, x0 -> dt 0, nick 0 for both.
- Rename x5→nick 3; next cycle read x5 -> nick 3. Commit x5 nick 3, dt 0xDEADBEEF; next cycle read -> dt 0xDEADBEEF, nick 0.
- Rename x7→nick 4, then x7→nick 9; commit x7 nick 4, dt 0x11 -> x7 reads nick 9. Commit nick 9, dt 0x22 -> dt 0x22, nick 0.
- Same cycle: commit x8 nick 2, dt 0x55 and rename x8→nick 6 -> next cycle nick 6. Commit x8 nick 6, dt 0x66 -> dt 0x66.
- Rename x1→1, x2→2; iclr with commit x3 dt 0x7 and rename x4→5 -> x1, x2, x4 nick 0; x3 dt 0x7.
- Bypass: x9 tagged nick 10; same cycle commit x9 nick 10, dt 0xABC and read x9 -> with macro dt 0xABC, nick 0; without, nick 10, then next cycle dt 0xABC.
- Commit/rename to x0 with dt 0xFFFF -> x0 reads 0, nick 0.

Source files
------------

// File: rtl/regfile_if.sv
// regfile_if: dispatch/ROB-facing bus of the architectural register file.
//   rdy              global enable (state holds when low)
//   iclr             misprediction flush
//   iROB_nick_en/iROB_nick/iROB_nick_regnm     rename allocation
//   iROB_en/iROB_rd_regnm/iROB_rd_dt/iROB_rd_nick   in-order commit
//   iDP_rs1_regnm/iDP_rs2_regnm                 source lookups
//   oDP_rs1_dt/oDP_rs1_nick/oDP_rs2_dt/oDP_rs2_nick  lookup results
// master = ROB/dispatch side (drives requests), slave = register file.
interface regfile_if;
    logic        rdy;
    logic        iclr;
    logic        iROB_nick_en;
    logic [4:0]  iROB_nick;
    logic [4:0]  iROB_nick_regnm;
    logic        iROB_en;
    logic [4:0]  iROB_rd_regnm;
    logic [31:0] iROB_rd_dt;
    logic [4:0]  iROB_rd_nick;
    logic [4:0]  iDP_rs1_regnm;
    logic [4:0]  iDP_rs2_regnm;
    logic [31:0] oDP_rs1_dt;
    logic [4:0]  oDP_rs1_nick;
    logic [31:0] oDP_rs2_dt;
    logic [4:0]  oDP_rs2_nick;

    modport master (
        output rdy, iclr, iROB_nick_en, iROB_nick, iROB_nick_regnm,
               iROB_en, iROB_rd_regnm, iROB_rd_dt, iROB_rd_nick,
               iDP_rs1_regnm, iDP_rs2_regnm,
        input  oDP_rs1_dt, oDP_rs1_nick, oDP_rs2_dt, oDP_rs2_nick
    );

    modport slave (
        input  rdy, iclr, iROB_nick_en, iROB_nick, iROB_nick_regnm,
               iROB_en, iROB_rd_regnm, iROB_rd_dt, iROB_rd_nick,
               iDP_rs1_regnm, iDP_rs2_regnm,
        output oDP_rs1_dt, oDP_rs1_nick, oDP_rs2_dt, oDP_rs2_nick
    );
endinterface

// File: rtl/regfile.sv
// regfile: 32 x 32-bit architectural registers, each with a 5-bit ROB nick
// naming its in-flight producer (0 = value ready).
// Ports:
//   clk  core clock, all state updates on posedge
//   rst  asynchronous active-high reset, clears all values and nicks
//   bus  regfile_if.slave: rename, commit, flush and two source lookups
// Reads are combinational from current state. Register 0 is hardwired to
// value 0 / nick 0.
// Optional feature: define RF_COMMIT_BYPASS_EN to forward a same-cycle commit
// whose nick matches the stored nick straight to the lookup outputs.
module regfile (
    input  logic     clk,
    input  logic     rst,
    regfile_if.slave bus
);

    logic [31:0] dt_q   [32];
    logic [31:0] dt_d   [32];
    logic [4:0]  nick_q [32];
    logic [4:0]  nick_d [32];

    // Lookup of one source register: returns {dt, nick}.
    function automatic logic [36:0] rd_lookup(
        input logic [4:0]  rs,
        input logic [31:0] st_dt,
        input logic [4:0]  st_nick,
        input logic        cm_en,
        input logic [4:0]  cm_regnm,
        input logic [4:0]  cm_nick,
        input logic [31:0] cm_dt
    );
        logic [36:0] res;
        logic        byp;
`ifdef RF_COMMIT_BYPASS_EN
        byp = cm_en && (cm_regnm == rs) && (st_nick == cm_nick);
`else
        byp = 1'b0;
        // Commit inputs are only consumed when forwarding is built in.
        if (cm_en && (cm_regnm == rs) && (cm_nick == st_nick) && (cm_dt == st_dt)) begin
            byp = 1'b0;
        end else begin
            byp = 1'b0;
        end
`endif
        if (rs == 5'd0) begin
            res = {32'd0, 5'd0};
        end else if (byp) begin
            res = {cm_dt, 5'd0};
        end else if (st_nick != 5'd0) begin
            // Pending producer: value is don't-care, driven 0.
            res = {32'd0, st_nick};
        end else begin
            res = {st_dt, 5'd0};
        end
        return res;
    endfunction

    // Next-state: flush clears nicks, commit writes data and retires a
    // matching nick, rename (applied last) wins over a same-cycle commit.
    always_comb begin
        dt_d   = dt_q;
        nick_d = nick_q;
        if (bus.rdy) begin
            if (bus.iclr) begin
                for (int i = 0; i < 32; i++) begin
                    nick_d[i] = 5'd0;
                end
            end else begin
                nick_d = nick_q;
            end
            if (bus.iROB_en && (bus.iROB_rd_regnm != 5'd0)) begin
                dt_d[bus.iROB_rd_regnm] = bus.iROB_rd_dt;
                // Only retire the tag if no younger rename replaced it.
                if (nick_q[bus.iROB_rd_regnm] == bus.iROB_rd_nick) begin
                    nick_d[bus.iROB_rd_regnm] = 5'd0;
                end else begin
                    nick_d[bus.iROB_rd_regnm] = nick_d[bus.iROB_rd_regnm];
                end
            end else begin
                dt_d = dt_q;
            end
            if (bus.iROB_nick_en && !bus.iclr && (bus.iROB_nick_regnm != 5'd0)) begin
                nick_d[bus.iROB_nick_regnm] = bus.iROB_nick;
            end else begin
                dt_d = dt_d;
            end
        end else begin
            dt_d   = dt_q;
            nick_d = nick_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                dt_q[i]   <= 32'd0;
                nick_q[i] <= 5'd0;
            end
        end else begin
            dt_q   <= dt_d;
            nick_q <= nick_d;
        end
    end

    // Source operand lookups.
    always_comb begin
        logic [36:0] r1;
        logic [36:0] r2;
        r1 = rd_lookup(bus.iDP_rs1_regnm, dt_q[bus.iDP_rs1_regnm], nick_q[bus.iDP_rs1_regnm],
                       bus.iROB_en && bus.rdy, bus.iROB_rd_regnm, bus.iROB_rd_nick, bus.iROB_rd_dt);
        r2 = rd_lookup(bus.iDP_rs2_regnm, dt_q[bus.iDP_rs2_regnm], nick_q[bus.iDP_rs2_regnm],
                       bus.iROB_en && bus.rdy, bus.iROB_rd_regnm, bus.iROB_rd_nick, bus.iROB_rd_dt);
        bus.oDP_rs1_dt   = r1[36:5];
        bus.oDP_rs1_nick = r1[4:0];
        bus.oDP_rs2_dt   = r2[36:5];
        bus.oDP_rs2_nick = r2[4:0];
    end

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

    logic clk;
    logic rst;
    regfile_if bus ();

    regfile u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Clear one-shot request strobes.
    task automatic idle();
        bus.iclr         = 1'b0;
        bus.iROB_nick_en = 1'b0;
        bus.iROB_en      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_rename(input logic [4:0] r, input logic [4:0] n);
        bus.iROB_nick_en    = 1'b1;
        bus.iROB_nick_regnm = r;
        bus.iROB_nick       = n;
    endtask

    task automatic do_commit(input logic [4:0] r, input logic [4:0] n, input logic [31:0] d);
        bus.iROB_en       = 1'b1;
        bus.iROB_rd_regnm = r;
        bus.iROB_rd_nick  = n;
        bus.iROB_rd_dt    = d;
    endtask

    // Drive both lookups, push expectations, let outputs settle, then pop and compare.
    task automatic rd(input string tag, input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] n1,
                      input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] n2);
        exp_t e;
        bus.iDP_rs1_regnm = rs1;
        bus.iDP_rs2_regnm = rs2;
        e.tag = {tag, "_rs1_dt"};   e.val = d1;          exp_q.push_back(e);
        e.tag = {tag, "_rs1_nick"}; e.val = {27'd0, n1}; exp_q.push_back(e);
        e.tag = {tag, "_rs2_dt"};   e.val = d2;          exp_q.push_back(e);
        e.tag = {tag, "_rs2_nick"}; e.val = {27'd0, n2}; exp_q.push_back(e);
        #2;
        e = exp_q.pop_front(); check_val(e.tag, bus.oDP_rs1_dt, e.val);
        e = exp_q.pop_front(); check_val(e.tag, {27'd0, bus.oDP_rs1_nick}, e.val);
        e = exp_q.pop_front(); check_val(e.tag, bus.oDP_rs2_dt, e.val);
        e = exp_q.pop_front(); check_val(e.tag, {27'd0, bus.oDP_rs2_nick}, e.val);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.rdy             = 1'b1;
        idle();
        bus.iROB_nick       = 5'd0;
        bus.iROB_nick_regnm = 5'd0;
        bus.iROB_rd_regnm   = 5'd0;
        bus.iROB_rd_dt      = 32'd0;
        bus.iROB_rd_nick    = 5'd0;
        bus.iDP_rs1_regnm   = 5'd0;
        bus.iDP_rs2_regnm   = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        rd("reset", 5'd5, 32'd0, 5'd0, 5'd0, 32'd0, 5'd0);

        // Rename is not visible in its own cycle.
        do_rename(5'd5, 5'd3);
        rd("ren_same_cyc", 5'd5, 32'd0, 5'd0, 5'd0, 32'd0, 5'd0);
        tick();
        rd("ren_x5", 5'd5, 32'd0, 5'd3, 5'd0, 32'd0, 5'd0);
        do_commit(5'd5, 5'd3, 32'hDEADBEEF);
        tick();
        rd("cmt_x5", 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 32'd0, 5'd0);

        // Older commit must not clear a younger rename.
        do_rename(5'd7, 5'd4);  tick();
        do_rename(5'd7, 5'd9);  tick();
        do_commit(5'd7, 5'd4, 32'h11); tick();
        rd("old_cmt_x7", 5'd7, 32'd0, 5'd9, 5'd5, 32'hDEADBEEF, 5'd0);
        do_commit(5'd7, 5'd9, 32'h22); tick();
        rd("new_cmt_x7", 5'd7, 32'h22, 5'd0, 5'd0, 32'd0, 5'd0);

        // Same-cycle commit and rename: rename wins the tag.
        do_commit(5'd8, 5'd2, 32'h55);
        do_rename(5'd8, 5'd6);
        tick();
        rd("cmt_ren_x8", 5'd8, 32'd0, 5'd6, 5'd7, 32'h22, 5'd0);
        do_commit(5'd8, 5'd6, 32'h66); tick();
        rd("cmt2_x8", 5'd8, 32'h66, 5'd0, 5'd0, 32'd0, 5'd0);

        // Flush with same-cycle commit (kept) and rename (dropped).
        do_rename(5'd1, 5'd1); tick();
        do_rename(5'd2, 5'd2); tick();
        rd("pre_flush", 5'd1, 32'd0, 5'd1, 5'd2, 32'd0, 5'd2);
        bus.iclr = 1'b1;
        do_commit(5'd3, 5'd7, 32'h7);
        do_rename(5'd4, 5'd5);
        tick();
        rd("flush_x1x2", 5'd1, 32'd0, 5'd0, 5'd2, 32'd0, 5'd0);
        rd("flush_x3x4", 5'd3, 32'h7, 5'd0, 5'd4, 32'd0, 5'd0);

        // Commit forwarding in the commit cycle.
        do_rename(5'd9, 5'd10); tick();
        do_commit(5'd9, 5'd10, 32'hABC);
`ifdef RF_COMMIT_BYPASS_EN
        rd("byp_same", 5'd9, 32'hABC, 5'd0, 5'd0, 32'd0, 5'd0);
`else
        rd("byp_same", 5'd9, 32'd0, 5'd10, 5'd0, 32'd0, 5'd0);
`endif
        tick();
        rd("byp_next", 5'd9, 32'hABC, 5'd0, 5'd0, 32'd0, 5'd0);

        // Writes to x0 are ignored.
        do_commit(5'd0, 5'd0, 32'hFFFF);
        do_rename(5'd0, 5'd3);
        tick();
        rd("x0_write", 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 5'd0);

        // rdy low freezes state.
        bus.rdy = 1'b0;
        do_rename(5'd10, 5'd12);
        do_commit(5'd5, 5'd0, 32'h1234);
        tick();
        bus.rdy = 1'b1;
        rd("rdy_low", 5'd10, 32'd0, 5'd0, 5'd5, 32'hDEADBEEF, 5'd0);

        // Asynchronous reset mid-operation.
        do_rename(5'd11, 5'd13); tick();
        rd("pre_rst", 5'd11, 32'd0, 5'd13, 5'd8, 32'h66, 5'd0);
        rst = 1'b1;
        rd("async_rst", 5'd11, 32'd0, 5'd0, 5'd8, 32'd0, 5'd0);
        rst = 1'b0;
        tick();
        rd("post_rst", 5'd5, 32'd0, 5'd0, 5'd9, 32'd0, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
